// File: rtl/cic_decim_mux.sv
// Multichannel time-multiplexed CIC decimator with round/saturate, output FIFO and a paced
// Data_Out_Valid generator sized for the downstream FIR's negedge capture.
module cic_decim_mux #(
    parameter int INPUT_WIDTH  = 24,
    parameter int OUTPUT_WIDTH = 24,
    parameter int CIC_ORDER    = 4,
    parameter int MAX_CHANNELS = 2,
    parameter int MAX_DECIM    = 64,
    parameter int ACC_WIDTH    = 48,
    parameter int VALID_HIGH   = 2,
    parameter int OUT_GAP      = 40,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           Cfg_Load,
    input  logic [7:0]                     Decim_Rate,
    input  logic [5:0]                     Shift_Sel,
    input  logic signed [INPUT_WIDTH-1:0]  Data_In,
    input  logic                           Data_In_Valid,
    input  logic [3:0]                     Data_In_ChIdx,
    output logic signed [OUTPUT_WIDTH-1:0] Data_Out,
    output logic                           Data_Out_Valid,
    output logic [3:0]                     Data_Out_ChIdx,
    output logic                           Sat_Flag,
    output logic                           Fifo_Ovf,
    output logic                           Cfg_Err
);
    localparam int CH_W = (MAX_CHANNELS > 1) ? $clog2(MAX_CHANNELS) : 1;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int GW   = $clog2(OUT_GAP + 1);
    localparam int RW   = ACC_WIDTH + 1;
    localparam logic [7:0]    MAX_R   = 8'(MAX_DECIM);
    localparam logic [4:0]    NCH     = 5'(MAX_CHANNELS);
    localparam logic [GW-1:0] VH_LAST = GW'(VALID_HIGH);
    localparam logic [GW-1:0] GP_LAST = GW'(OUT_GAP - 1);
    localparam logic signed [RW-1:0] OMAX = {{(RW-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] OMIN = {{(RW-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    logic [7:0] rate;
    logic [5:0] shift;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rate    <= 8'd16;
            shift   <= 6'd16;
            Cfg_Err <= 1'b0;
        end else if (Cfg_Load) begin
            shift <= Shift_Sel;
            if (Decim_Rate < 8'd2 || Decim_Rate > MAX_R) Cfg_Err <= 1'b1;
            else                                         rate    <= Decim_Rate;
        end
    end

    logic signed [ACC_WIDTH-1:0] integ [MAX_CHANNELS][CIC_ORDER];
    logic signed [ACC_WIDTH-1:0] integ_nxt [CIC_ORDER];
    logic [7:0]                  cnt [MAX_CHANNELS];
    logic                        in_ok;
    logic [CH_W-1:0]             in_ch;
    logic                        ev_valid;
    logic [CH_W-1:0]             ev_ch;
    logic signed [ACC_WIDTH-1:0] ev_data;

    assign in_ok = Data_In_Valid && !Cfg_Load && ({1'b0, Data_In_ChIdx} < NCH);
    assign in_ch = Data_In_ChIdx[CH_W-1:0];

    // Each integrator adds the freshly updated value of the stage before it.
    always_comb begin
        integ_nxt[0] = integ[in_ch][0] + {{(ACC_WIDTH-INPUT_WIDTH){Data_In[INPUT_WIDTH-1]}}, Data_In};
        for (int k = 1; k < CIC_ORDER; k++)
            integ_nxt[k] = integ[in_ch][k] + integ_nxt[k-1];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST || Cfg_Load) begin
            for (int c = 0; c < MAX_CHANNELS; c++) begin
                cnt[c] <= 8'd0;
                for (int k = 0; k < CIC_ORDER; k++) integ[c][k] <= '0;
            end
            ev_valid <= 1'b0;
            ev_ch    <= '0;
            ev_data  <= '0;
        end else begin
            ev_valid <= 1'b0;
            if (in_ok) begin
                for (int k = 0; k < CIC_ORDER; k++) integ[in_ch][k] <= integ_nxt[k];
                if (cnt[in_ch] + 8'd1 >= rate) begin
                    cnt[in_ch] <= 8'd0;
                    ev_valid   <= 1'b1;
                    ev_ch      <= in_ch;
                    ev_data    <= integ_nxt[CIC_ORDER-1];
                end else begin
                    cnt[in_ch] <= cnt[in_ch] + 8'd1;
                end
            end
        end
    end

    logic signed [ACC_WIDTH-1:0] dly [MAX_CHANNELS][CIC_ORDER];
    logic signed [ACC_WIDTH-1:0] comb_c [CIC_ORDER+1];
    logic                        cm_valid;
    logic [CH_W-1:0]             cm_ch;
    logic signed [ACC_WIDTH-1:0] cm_data;

    always_comb begin
        comb_c[0] = ev_data;
        for (int k = 0; k < CIC_ORDER; k++)
            comb_c[k+1] = comb_c[k] - dly[ev_ch][k];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST || Cfg_Load) begin
            for (int c = 0; c < MAX_CHANNELS; c++)
                for (int k = 0; k < CIC_ORDER; k++) dly[c][k] <= '0;
            cm_valid <= 1'b0;
            cm_ch    <= '0;
            cm_data  <= '0;
        end else begin
            cm_valid <= ev_valid;
            if (ev_valid) begin
                for (int k = 0; k < CIC_ORDER; k++) dly[ev_ch][k] <= comb_c[k];
                cm_ch   <= ev_ch;
                cm_data <= comb_c[CIC_ORDER];
            end
        end
    end

    // One extra bit keeps the rounding offset from wrapping a near-full-scale comb result.
    logic [RW-1:0]                  half;
    logic signed [RW-1:0]           rnd_sum;
    logic signed [RW-1:0]           rnd_shr;
    logic signed [OUTPUT_WIDTH-1:0] y;
    logic                           clip;

    always_comb begin
        half = '0;
        if (shift != 6'd0) half = RW'(1) << (shift - 6'd1);
        rnd_sum = $signed({cm_data[ACC_WIDTH-1], cm_data}) + $signed(half);
        rnd_shr = rnd_sum >>> shift;
        clip    = 1'b0;
        y       = rnd_shr[OUTPUT_WIDTH-1:0];
        if (rnd_shr > OMAX) begin
            clip = 1'b1;
            y    = OMAX[OUTPUT_WIDTH-1:0];
        end else if (rnd_shr < OMIN) begin
            clip = 1'b1;
            y    = OMIN[OUTPUT_WIDTH-1:0];
        end
    end

    logic signed [OUTPUT_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [3:0]                     fifo_ch [FIFO_DEPTH];
    logic [PW-1:0]                  wr_ptr, rd_ptr;
    logic [CW-1:0]                  count;
    logic                           pop, push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push = cm_valid && ((count != CW'(FIFO_DEPTH)) || pop);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            Sat_Flag <= 1'b0;
            Fifo_Ovf <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_ch[i]   <= 4'd0;
            end
        end else if (Cfg_Load) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (cm_valid && clip) Sat_Flag <= 1'b1;
            if (cm_valid && !push) Fifo_Ovf <= 1'b1;
            if (push) begin
                fifo_data[wr_ptr] <= y;
                fifo_ch[wr_ptr]   <= 4'(cm_ch);
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    state_t        state, state_nxt;
    logic [GW-1:0] gap_cnt, gap_cnt_nxt;
    logic          valid_nxt;

    // gap_cnt counts edges since the Valid rise, so DRIVE and GAP share one timer.
    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        valid_nxt   = Data_Out_Valid;
        pop         = 1'b0;
        case (state)
            IDLE: if (count != '0 && !Cfg_Load) begin
                pop         = 1'b1;
                valid_nxt   = 1'b1;
                gap_cnt_nxt = GW'(1);
                state_nxt   = DRIVE;
            end
            DRIVE: begin
                gap_cnt_nxt = gap_cnt + GW'(1);
                if (gap_cnt >= VH_LAST) begin
                    valid_nxt = 1'b0;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                gap_cnt_nxt = gap_cnt + GW'(1);
                if (gap_cnt >= GP_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state          <= IDLE;
            gap_cnt        <= '0;
            Data_Out_Valid <= 1'b0;
            Data_Out       <= '0;
            Data_Out_ChIdx <= 4'd0;
        end else if (Cfg_Load) begin
            state          <= IDLE;
            gap_cnt        <= '0;
            Data_Out_Valid <= 1'b0;
        end else begin
            state          <= state_nxt;
            gap_cnt        <= gap_cnt_nxt;
            Data_Out_Valid <= valid_nxt;
            if (pop) begin
                Data_Out       <= fifo_data[rd_ptr];
                Data_Out_ChIdx <= fifo_ch[rd_ptr];
            end
        end
    end
endmodule
